sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Two-port round-robin arbiter and sequencer for the single-port 160x32 SRAM macro
//  (ST_SPHDL_160x32m8_L). Shares the macro between a write requester (loader) and a
//  read requester (compute/unpacker), drives active-low CSN/WEN and honours RY.
//  Returns read data with a one-cycle valid pulse. Sits between the requesters and the macro.
// PARAMETERS
//  AW         8    address width
//  DW         32   data width
//  DEPTH      160  number of valid words in the macro
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  wr_req      in   1   write request; held with wr_addr/wr_data stable until wr_gnt
//  wr_addr     in   AW  write address
//  wr_data     in   DW  write data
//  wr_gnt      out  1   1-cycle pulse: write accepted and issued
//  rd_req      in   1   read request; held with rd_addr stable until rd_gnt
//  rd_addr     in   AW  read address
//  rd_gnt      out  1   1-cycle pulse: read accepted and issued
//  rd_data     out  DW  read data, valid when rd_valid=1, held until next read return
//  rd_valid    out  1   1-cycle pulse: rd_data updated
//  busy        out  1   1 whenever state != IDLE
//  addr_err    out  1   1-cycle pulse: out-of-range access (tied 0 without macro below)
//  sram_csn    out  1   macro chip select, active low
//  sram_wen    out  1   macro write enable, active low (0=write, 1=read)
//  sram_addr   out  AW  macro address
//  sram_d      out  DW  macro write data
//  sram_q      in   DW  macro read data
//  sram_ry     in   1   macro ready; no new access issued while 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, sram_csn=1, sram_wen=1, sram_addr=0, sram_d=0,
//    wr_gnt=rd_gnt=rd_valid=addr_err=0, rd_data=0, last_wr=0. In-flight read is discarded.
//  - All macro-side outputs and gnt/valid are registered.
//  - FSM IDLE -> ISSUE -> WAIT -> IDLE.
//    IDLE: if sram_ry=1 and (wr_req|rd_req): select winner, register csn=0, wen, addr, d,
//      pulse matching gnt -> ISSUE. Else hold csn=1.
//    ISSUE: csn=1, wen=1 (macro sampled the access on this cycle's edge) -> WAIT.
//    WAIT: stay until sram_ry=1; then for a read capture sram_q into rd_data and pulse
//      rd_valid (registered, next cycle) -> IDLE. Writes -> IDLE with no data return.
//  - Arbitration: only one requester -> it wins. Both -> the one not served last
//    (last_wr flag); after reset the write wins first. No starvation: strict alternation.
//  - Timing (sram_ry=1 throughout): req seen cycle 0, gnt+csn=0 cycle 1, rd_valid cycle 3.
//    Max throughput one access per 3 cycles.
//  - sram_ry=0 in IDLE: requests wait, no gnt. sram_ry=0 in WAIT: stall, rd_data unchanged.
//  - Requests deasserted before gnt are simply not served; no state retained.
//  - req asserted during ISSUE/WAIT is evaluated only on return to IDLE.
// CONFIGURATION
//  SRAM_ARB_RANGE_CHECK_EN defined: address >= DEPTH is granted normally (gnt pulse, FSM
//   runs) but sram_csn stays 1; addr_err pulses with gnt; a read returns rd_data=0 with
//   rd_valid pulse at the normal cycle.
//  Not defined: addresses passed through unchecked; addr_err tied 0.
// TESTING
//  1 wr_req addr=8'h05 data=32'hA5A5_1234, then rd_req addr=8'h05 -> wr_gnt pulse,
//    sram_csn=0/wen=0; later rd_valid with rd_data=32'hA5A5_1234, 3 cycles after rd_req.
//  2 wr_req and rd_req both held from reset -> grants wr,rd,wr,rd alternating; no gnt
//    while busy=1.
//  3 sram_ry forced 0 for 5 cycles during WAIT of a read -> rd_valid delayed exactly 5
//    cycles; no new csn=0 while ry=0.
//  4 rst_n pulsed low in WAIT of a read -> outputs at reset values immediately (async),
//    no rd_valid after release; next read completes normally.
//  5 (with SRAM_ARB_RANGE_CHECK_EN) rd_req addr=8'd160 -> rd_gnt+addr_err pulse,
//    sram_csn never 0, rd_valid with rd_data=0.
//  6 back-to-back reads addr 0..159 preloaded with addr value -> 160 rd_valid pulses,
//    rd_data==addr each time.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin write/read sequencer for a single-port SRAM macro.
// Optional macro SRAM_ARB_RANGE_CHECK_EN: block macro access for addr >= DEPTH.
module sram_arbiter #(
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int DEPTH = 160
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          addr_err,
    output logic          sram_csn,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q,
    input  logic          sram_ry
);

`ifdef SRAM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          csn_q, csn_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          wr_gnt_q, wr_gnt_d;
    logic          rd_gnt_q, rd_gnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic          err_q, err_d;
    logic          last_wr_q, last_wr_d;
    logic          op_rd_q, op_rd_d;
    logic          bad_q, bad_d;

    logic          pick_wr;
    logic [AW-1:0] pick_addr;
    logic          pick_bad;

    // Winner: a lone requester, else whoever was not served last.
    assign pick_wr   = wr_req && (!rd_req || !last_wr_q);
    assign pick_addr = pick_wr ? wr_addr : rd_addr;
    assign pick_bad  = RANGE_EN && (int'(pick_addr) >= DEPTH);

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d    = state_q;
        csn_d      = 1'b1;
        wen_d      = 1'b1;
        addr_d     = addr_q;
        d_d        = d_q;
        rd_data_d  = rd_data_q;
        wr_gnt_d   = 1'b0;
        rd_gnt_d   = 1'b0;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        last_wr_d  = last_wr_q;
        op_rd_d    = op_rd_q;
        bad_d      = bad_q;
        unique case (state_q)
            S_IDLE: begin
                if (sram_ry && (wr_req || rd_req)) begin
                    state_d   = S_ISSUE;
                    csn_d     = pick_bad;
                    wen_d     = !pick_wr || pick_bad;
                    addr_d    = pick_addr;
                    if (pick_wr) d_d = wr_data;
                    wr_gnt_d  = pick_wr;
                    rd_gnt_d  = !pick_wr;
                    err_d     = pick_bad;
                    last_wr_d = pick_wr;
                    op_rd_d   = !pick_wr;
                    bad_d     = pick_bad;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sram_ry) begin
                    state_d = S_IDLE;
                    if (op_rd_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bad_q ? '0 : sram_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            csn_q      <= 1'b1;
            wen_q      <= 1'b1;
            addr_q     <= '0;
            d_q        <= '0;
            rd_data_q  <= '0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            last_wr_q  <= 1'b0;
            op_rd_q    <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            csn_q      <= csn_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            d_q        <= d_d;
            rd_data_q  <= rd_data_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            last_wr_q  <= last_wr_d;
            op_rd_q    <= op_rd_d;
            bad_q      <= bad_d;
        end
    end

    assign sram_csn  = csn_q;
    assign sram_wen  = wen_q;
    assign sram_addr = addr_q;
    assign sram_d    = d_q;
    assign rd_data   = rd_data_q;
    assign wr_gnt    = wr_gnt_q;
    assign rd_gnt    = rd_gnt_q;
    assign rd_valid  = rd_valid_q;
    assign addr_err  = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed + random checks of sram_arbiter against a
// transaction-level reference model and a behavioural SRAM macro.
module tb_sram_arbiter;

`ifdef SRAM_ARB_RANGE_CHECK_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        sram_ry = 1'b1;
    logic [31:0] sram_q = '0;
    logic        wr_gnt, rd_gnt, rd_valid, busy, addr_err;
    logic        sram_csn, sram_wen;
    logic [7:0]  sram_addr;
    logic [31:0] sram_d, rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .addr_err(addr_err),
        .sram_csn(sram_csn), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_d(sram_d),
        .sram_q(sram_q), .sram_ry(sram_ry)
    );

    // Behavioural macro: unwritten words read back as their own address.
    logic [31:0] macro_mem [256];
    bit          macro_wr  [256];
    always @(posedge clk) begin
        if (!sram_csn) begin
            if (!sram_wen) begin
                macro_mem[sram_addr] <= sram_d;
                macro_wr[sram_addr]  <= 1'b1;
            end else begin
                sram_q <= macro_wr[sram_addr] ? macro_mem[sram_addr]
                                              : {24'd0, sram_addr};
            end
        end
    end

    // Reference model: one outstanding transaction, memory image, expectations.
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    bit          m_active, m_last_wr, m_rd;
    int          m_age;
    logic [31:0] m_pending;
    logic        e_wg, e_rg, e_v, e_err, e_csn, e_wen;
    logic [7:0]  e_addr;
    logic [31:0] e_d, e_data;
    int          cyc = 0;

    function automatic logic [31:0] ref_read(input logic [7:0] a);
        return ref_wr[a] ? ref_mem[a] : {24'd0, a};
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_last_wr = 1'b0; m_rd = 1'b0; m_age = 0;
        e_wg = 0; e_rg = 0; e_v = 0; e_err = 0; e_csn = 1; e_wen = 1;
        e_addr = '0; e_d = '0; e_data = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_csn"}, sram_csn, 1);
        chk({tag, "_wen"}, sram_wen, 1);
        chk({tag, "_addr"}, sram_addr, 0);
        chk({tag, "_d"}, sram_d, 0);
        chk({tag, "_wgnt"}, wr_gnt, 0);
        chk({tag, "_rgnt"}, rd_gnt, 0);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_err"}, addr_err, 0);
        chk({tag, "_rdata"}, rd_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Apply one cycle of inputs, predict the edge, then compare all outputs.
    task automatic step(input bit w, input logic [7:0] wa,
                        input logic [31:0] wd, input bit r,
                        input logic [7:0] ra, input bit ry);
        bit         pw, bad;
        logic [7:0] a;
        wr_req = w; wr_addr = wa; wr_data = wd;
        rd_req = r; rd_addr = ra; sram_ry = ry;
        e_wg = 0; e_rg = 0; e_v = 0; e_err = 0; e_csn = 1; e_wen = 1;
        if (!m_active) begin
            if (ry && (w || r)) begin
                pw = w && !(r && m_last_wr);
                a = pw ? wa : ra;
                bad = RANGE && (a >= 8'd160);
                m_active = 1; m_age = 0; m_last_wr = pw; m_rd = !pw;
                e_wg = pw; e_rg = !pw; e_err = bad;
                e_csn = bad; e_wen = !(pw && !bad); e_addr = a;
                if (pw) e_d = wd;
                if (pw && !bad) begin
                    ref_mem[a] = wd;
                    ref_wr[a] = 1'b1;
                end
                m_pending = bad ? 32'd0 : ref_read(a);
            end
        end else begin
            m_age++;
            if (m_age >= 2 && ry) begin
                m_active = 0;
                if (m_rd) begin
                    e_v = 1;
                    e_data = m_pending;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("wr_gnt", wr_gnt, e_wg);
        chk("rd_gnt", rd_gnt, e_rg);
        chk("rd_valid", rd_valid, e_v);
        chk("rd_data", rd_data, e_data);
        chk("addr_err", addr_err, e_err);
        chk("sram_csn", sram_csn, e_csn);
        chk("sram_wen", sram_wen, e_wen);
        chk("sram_addr", sram_addr, e_addr);
        chk("sram_d", sram_d, e_d);
        chk("busy", busy, m_active);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        chk_reset("rst");
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        int idx, nv, nexp, ng;
        model_reset();
        #12;
        chk_reset("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back reads of the preloaded image 0..159.
        idx = 0; nv = 0; nexp = 0;
        for (int k = 0; k < 600 && nv < 160; k++) begin
            step(0, 8'h0, 32'h0, idx < 160, 8'(idx), 1);
            if (e_rg) idx++;
            if (rd_valid) begin
                chk("t6_seq", rd_data, 32'(nexp));
                nexp++;
                nv++;
            end
        end
        chk("t6_count", nv, 160);

        // Write then read back address 5.
        step(1, 8'h05, 32'hA5A5_1234, 0, 8'h0, 1);
        chk("t1_wgnt", wr_gnt, 1);
        chk("t1_csn", sram_csn, 0);
        chk("t1_wen", sram_wen, 0);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        step(0, 8'h0, 32'h0, 1, 8'h05, 1);
        chk("t1_rgnt", rd_gnt, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        chk("t1_valid", rd_valid, 1);
        chk("t1_data", rd_data, 32'hA5A5_1234);

        // Ready low for 5 cycles during a read's wait.
        step(0, 8'h0, 32'h0, 1, 8'h05, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        for (int k = 0; k < 5; k++) begin
            step(1, 8'h22, 32'h1357_9BDF, 0, 8'h0, 0);
            chk("t3_csn", sram_csn, 1);
            chk("t3_novalid", rd_valid, 0);
        end
        step(1, 8'h22, 32'h1357_9BDF, 0, 8'h0, 1);
        chk("t3_valid", rd_valid, 1);
        chk("t3_data", rd_data, 32'hA5A5_1234);
        step(1, 8'h22, 32'h1357_9BDF, 0, 8'h0, 1);
        chk("t3_wgnt", wr_gnt, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);

        // Asynchronous reset during a read's wait.
        step(0, 8'h0, 32'h0, 1, 8'h05, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 0);
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            step(0, 8'h0, 32'h0, 0, 8'h0, 1);
            chk("t4_novalid", rd_valid, 0);
        end
        step(0, 8'h0, 32'h0, 1, 8'h05, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        chk("t4_valid", rd_valid, 1);
        chk("t4_data", rd_data, 32'hA5A5_1234);

        // Both requests held from reset: strict alternation, write first.
        pulse_reset();
        ng = 0;
        for (int k = 0; k < 12; k++) begin
            step(1, 8'h30, $urandom, 1, 8'h31, 1);
            if (wr_gnt || rd_gnt) begin
                chk("t2_order", wr_gnt, (ng % 2 == 0) ? 1 : 0);
                ng++;
            end
        end
        chk("t2_count", ng, 4);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);

`ifdef SRAM_ARB_RANGE_CHECK_EN
        // Out-of-range read: granted, flagged, no macro access, zero data.
        step(0, 8'h0, 32'h0, 1, 8'd160, 1);
        chk("t5_rgnt", rd_gnt, 1);
        chk("t5_err", addr_err, 1);
        chk("t5_csn", sram_csn, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        chk("t5_csn2", sram_csn, 1);
        step(0, 8'h0, 32'h0, 0, 8'h0, 1);
        chk("t5_valid", rd_valid, 1);
        chk("t5_data", rd_data, 0);
`endif

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] wa, ra;
            wa = RANGE ? 8'($urandom_range(0, 175)) : 8'($urandom_range(0, 255));
            ra = RANGE ? 8'($urandom_range(0, 175)) : 8'($urandom_range(0, 255));
            step($urandom_range(0, 1) == 1, wa, $urandom,
                 $urandom_range(0, 1) == 1, ra,
                 $urandom_range(0, 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
